// File: rtl/iq_fir_sched.sv
// ---------------------------------------------------------------------------------------------
// iq_fir_sched - feeds I/Q samples into a clock-enabled FIR and buffers its results.
//
// The FIR runs off i_clk_x16 and is gated by o_fir_en. Whenever the FIR requests a sample
// (i_fir_ready) while running, the scheduler loads the next upstream sample into o_fir_I/Q.
// If nothing is available, a zero sample is loaded and o_underrun pulses. FIR results
// (i_fir_valid) are queued in a small output FIFO towards the downstream consumer.
//
// Stopping is graceful: after i_run drops, the FIR keeps clocking until its next
// sample-request phase, so it always halts at the same point in its cycle.
//
// Optional build macro IQ_FIR_SCHED_STATS_EN adds saturating 16-bit event counters
// o_underrun_cnt and o_overflow_cnt.
//
// Ports:
//   i_clk_x16                 clock, 16x sample rate
//   i_rst                     synchronous active-high reset (shared with the FIR)
//   i_run                     level request to run the filter
//   i_sym_valid/o_sym_ready   upstream handshake, data on i_sym_I/i_sym_Q
//   o_fir_en                  FIR clock enable
//   o_fir_I/o_fir_Q           registered sample presented to the FIR
//   i_fir_ready               FIR sample-request strobe
//   i_fir_valid               FIR result strobe, data on i_fir_I/i_fir_Q
//   o_valid/i_ready           downstream handshake, data on o_I/o_Q (zero when empty)
//   o_underrun/o_overflow     single-cycle event pulses
//   o_busy                    scheduler not idle
// ---------------------------------------------------------------------------------------------

module iq_fir_sched #(
  parameter int unsigned OFIFO_DEPTH = 2
) (
  input  logic        i_clk_x16,
  input  logic        i_rst,
  input  logic        i_run,
  // upstream samples
  input  logic        i_sym_valid,
  output logic        o_sym_ready,
  input  logic [7:0]  i_sym_I,
  input  logic [7:0]  i_sym_Q,
  // FIR side
  output logic        o_fir_en,
  output logic [7:0]  o_fir_I,
  output logic [7:0]  o_fir_Q,
  input  logic        i_fir_ready,
  input  logic        i_fir_valid,
  input  logic [15:0] i_fir_I,
  input  logic [15:0] i_fir_Q,
  // downstream results
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_I,
  output logic [15:0] o_Q,
  // status
  output logic        o_underrun,
  output logic        o_overflow,
`ifdef IQ_FIR_SCHED_STATS_EN
  output logic [15:0] o_underrun_cnt,
  output logic [15:0] o_overflow_cnt,
`endif
  output logic        o_busy
);

  localparam int unsigned PtrW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(OFIFO_DEPTH);

  // -------------------------------------------------------------------------------------------
  // Run/stop state machine
  // -------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_run) state_d = StRun;
      end
      StRun: begin
        if (!i_run) state_d = StStopping;
      end
      StStopping: begin
        // The sample-request phase wins: the FIR is parked there before any restart.
        if (i_fir_ready) begin
          state_d = StIdle;
        end else if (i_run) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_x16) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Enable drops in the very cycle the FIR asks for a sample while stopping, so it freezes
  // exactly at its request phase.
  assign o_fir_en = (state_q == StRun) || ((state_q == StStopping) && !i_fir_ready);
  assign o_busy   = (state_q != StIdle);

  // -------------------------------------------------------------------------------------------
  // Input holding register and FIR sample register
  // -------------------------------------------------------------------------------------------
  logic        held_q, held_d;
  logic [15:0] held_data_q, held_data_d;   // {I, Q}
  logic [15:0] fir_data_q, fir_data_d;     // {I, Q}
  logic        underrun_q, underrun_d;
  logic        load;
  logic        sym_hs;

  assign load        = (state_q == StRun) && i_fir_ready;
  // A full holding register still accepts on a load cycle since it is emptied at that edge.
  assign o_sym_ready = !held_q || load;
  assign sym_hs      = i_sym_valid && o_sym_ready;

  always_comb begin
    held_d      = held_q;
    held_data_d = held_data_q;
    fir_data_d  = fir_data_q;
    underrun_d  = 1'b0;
    if (load) begin
      if (held_q) begin
        fir_data_d = held_data_q;
        held_d     = sym_hs;
        if (sym_hs) held_data_d = {i_sym_I, i_sym_Q};
      end else if (sym_hs) begin
        // Nothing queued: pass the arriving sample straight through.
        fir_data_d = {i_sym_I, i_sym_Q};
      end else begin
        fir_data_d = '0;
        underrun_d = 1'b1;
      end
    end else if (sym_hs) begin
      held_d      = 1'b1;
      held_data_d = {i_sym_I, i_sym_Q};
    end
  end

  always_ff @(posedge i_clk_x16) begin
    if (i_rst) begin
      held_q      <= 1'b0;
      held_data_q <= '0;
      fir_data_q  <= '0;
      underrun_q  <= 1'b0;
    end else begin
      held_q      <= held_d;
      held_data_q <= held_data_d;
      fir_data_q  <= fir_data_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_fir_I    = fir_data_q[15:8];
  assign o_fir_Q    = fir_data_q[7:0];
  assign o_underrun = underrun_q;

  // -------------------------------------------------------------------------------------------
  // Output FIFO
  // -------------------------------------------------------------------------------------------
  logic [31:0]     mem_q [OFIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push_ok;

  assign fifo_full  = (count_q == FullCnt);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && i_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok    = i_fir_valid && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = i_fir_valid && fifo_full && !pop;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk_x16) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: it is never visible while the FIFO is empty.
  always_ff @(posedge i_clk_x16) begin
    if (!i_rst && push_ok) begin
      mem_q[wr_ptr_q] <= {i_fir_I, i_fir_Q};
    end
  end

  assign o_valid    = !fifo_empty;
  assign o_I        = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q][31:16];
  assign o_Q        = fifo_empty ? 16'h0000 : mem_q[rd_ptr_q][15:0];
  assign o_overflow = overflow_q;

  // -------------------------------------------------------------------------------------------
  // Optional event counters
  // -------------------------------------------------------------------------------------------
`ifdef IQ_FIR_SCHED_STATS_EN
  logic [15:0] urun_cnt_q, urun_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    urun_cnt_d = urun_cnt_q;
    ovf_cnt_d  = ovf_cnt_q;
    if (underrun_q && (urun_cnt_q != 16'hFFFF)) urun_cnt_d = urun_cnt_q + 16'd1;
    if (overflow_q && (ovf_cnt_q != 16'hFFFF))  ovf_cnt_d  = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk_x16) begin
    if (i_rst) begin
      urun_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      urun_cnt_q <= urun_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign o_underrun_cnt = urun_cnt_q;
  assign o_overflow_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_iq_fir_sched.sv
// ---------------------------------------------------------------------------------------------
// tb_iq_fir_sched - directed bench for iq_fir_sched (OFIFO_DEPTH = 2).
// Inputs change 2 time units after the rising edge; outputs are sampled on the falling edge.
// Expected FIFO results are queued when issued and popped by an independent monitor.
// ---------------------------------------------------------------------------------------------

module tb_iq_fir_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        sym_valid = 1'b0;
  logic        sym_ready;
  logic [7:0]  sym_i = '0;
  logic [7:0]  sym_q = '0;
  logic        fir_en;
  logic [7:0]  fir_i;
  logic [7:0]  fir_q;
  logic        fir_ready = 1'b0;
  logic        fir_valid = 1'b0;
  logic [15:0] fir_res_i = '0;
  logic [15:0] fir_res_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_i;
  logic [15:0] out_q;
  logic        underrun;
  logic        overflow;
  logic        busy;
`ifdef IQ_FIR_SCHED_STATS_EN
  logic [15:0] underrun_cnt;
  logic [15:0] overflow_cnt;
`endif

  iq_fir_sched #(
    .OFIFO_DEPTH(2)
  ) dut (
    .i_clk_x16   (clk),
    .i_rst       (rst),
    .i_run       (run),
    .i_sym_valid (sym_valid),
    .o_sym_ready (sym_ready),
    .i_sym_I     (sym_i),
    .i_sym_Q     (sym_q),
    .o_fir_en    (fir_en),
    .o_fir_I     (fir_i),
    .o_fir_Q     (fir_q),
    .i_fir_ready (fir_ready),
    .i_fir_valid (fir_valid),
    .i_fir_I     (fir_res_i),
    .i_fir_Q     (fir_res_q),
    .o_valid     (out_valid),
    .i_ready     (out_ready),
    .o_I         (out_i),
    .o_Q         (out_q),
    .o_underrun  (underrun),
    .o_overflow  (overflow),
`ifdef IQ_FIR_SCHED_STATS_EN
    .o_underrun_cnt (underrun_cnt),
    .o_overflow_cnt (overflow_cnt),
`endif
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int urun_seen  = 0;
  int urun_total = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted downstream beat must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {out_i, out_q}, 32'hxxxx_xxxx);
      end else begin
        check("fifo_out", {out_i, out_q}, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (underrun) begin
      urun_seen++;
      urun_total++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // FIR model: one sample request every 16 cycles; returns at the falling edge of the cycle
  // following the last request edge, when the freshly loaded sample is visible.
  task automatic fir_pulses(input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 16; c++) begin
        step();
        fir_ready = (c == 15);
      end
    end
    step();
    fir_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_fir_en", fir_en, 0);
    check("rst_fir_iq", {fir_i, fir_q}, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sym_ready", sym_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulses", {underrun, overflow}, 0);
    check("rst_out_iq", {out_i, out_q}, 0);

    // Held sample, FIR requesting every 16 cycles: always loads 10/20, no underrun
    step();
    rst = 1'b0; run = 1'b1; sym_valid = 1'b1; sym_i = 8'h10; sym_q = 8'h20;
    @(negedge clk);
    check("idle_sym_ready", sym_ready, 1);
    step();
    urun_seen = 0;
    @(negedge clk);
    check("run_busy", busy, 1);
    check("run_fir_en", fir_en, 1);
    check("held_sym_ready", sym_ready, 0);
    fir_pulses(1);
    check("first_load", {fir_i, fir_q}, 32'h1020);
    fir_pulses(2);
    check("steady_load", {fir_i, fir_q}, 32'h1020);
    check("no_underrun", urun_seen, 0);

    // Starved: held sample consumed once, then zero loads with one underrun per request
    step();
    sym_valid = 1'b0; urun_seen = 0;
    fir_pulses(3);
    check("starved_load", {fir_i, fir_q}, 0);
    check("underrun_now", underrun, 1);
    step();
    @(negedge clk);
    check("underrun_single", underrun, 0);
    check("underrun_count", urun_seen, 2);

    // Graceful stop with a held sample, then resume
    step();
    sym_valid = 1'b1; sym_i = 8'h33; sym_q = 8'h44;
    @(negedge clk);
    check("accept_33", sym_ready, 1);
    step();
    sym_valid = 1'b0; run = 1'b0;
    @(negedge clk);
    check("held_33_ready", sym_ready, 0);
    step();
    @(negedge clk);
    check("stopping_en", fir_en, 1);
    check("stopping_busy", busy, 1);
    repeat (3) step();
    @(negedge clk);
    check("stopping_en_hold", fir_en, 1);
    step();
    fir_ready = 1'b1;
    @(negedge clk);
    check("stop_phase_en", fir_en, 0);
    step();
    fir_ready = 1'b0;
    @(negedge clk);
    check("stopped_busy", busy, 0);
    check("stopped_en", fir_en, 0);
    check("stopped_fir_iq", {fir_i, fir_q}, 0);
    step();
    run = 1'b1; urun_seen = 0;
    fir_pulses(1);
    check("resume_load", {fir_i, fir_q}, 32'h3344);
    step();
    @(negedge clk);
    check("resume_no_underrun", urun_seen, 0);
`ifdef IQ_FIR_SCHED_STATS_EN
    check("underrun_cnt", underrun_cnt, urun_total);
`endif

    // Output FIFO: fill to depth 2, overflow on the third, then drain in order
    step();
    fir_valid = 1'b1; fir_res_i = 16'h1111; fir_res_q = 16'h2222;
    exp_q.push_back(32'h1111_2222);
    @(negedge clk);
    check("fifo_empty_before", out_valid, 0);
    step();
    fir_valid = 1'b1; fir_res_i = 16'h3333; fir_res_q = 16'h4444;
    exp_q.push_back(32'h3333_4444);
    @(negedge clk);
    check("result_latency", out_valid, 1);
    check("head_a", {out_i, out_q}, 32'h1111_2222);
    step();
    fir_valid = 1'b1; fir_res_i = 16'h5555; fir_res_q = 16'h6666;
    @(negedge clk);
    check("no_overflow_yet", overflow, 0);
    step();
    fir_valid = 1'b0;
    @(negedge clk);
    check("overflow_pulse", overflow, 1);
    step();
    @(negedge clk);
    check("overflow_single", overflow, 0);
    step();
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("drained_valid", out_valid, 0);
    check("drained_iq_zero", {out_i, out_q}, 0);

    // Push and pop together while full: no drop
    step();
    out_ready = 1'b0;
    fir_valid = 1'b1; fir_res_i = 16'hD0D0; fir_res_q = 16'hD1D1;
    exp_q.push_back(32'hD0D0_D1D1);
    step();
    fir_res_i = 16'hE0E0; fir_res_q = 16'hE1E1;
    exp_q.push_back(32'hE0E0_E1E1);
    step();
    out_ready = 1'b1; fir_res_i = 16'hF0F0; fir_res_q = 16'hF1F1;
    exp_q.push_back(32'hF0F0_F1F1);
    step();
    fir_valid = 1'b0;
    @(negedge clk);
    check("full_pushpop_no_ovf", overflow, 0);
    step();
    step();
    out_ready = 1'b0;
    @(negedge clk);
    check("drained2_valid", out_valid, 0);

    // Reset while running with one queued result: everything discarded
    step();
    fir_valid = 1'b1; fir_res_i = 16'hBAD0; fir_res_q = 16'hBAD1;
    step();
    fir_valid = 1'b0;
    @(negedge clk);
    check("one_queued", out_valid, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; run = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_en", fir_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_fir_iq", {fir_i, fir_q}, 0);

    repeat (4) step();
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
